// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: result-select encodings,
// halt state encoding and the default datapath width.
package writeback_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_PC   = 2'b10,
    WB_SEL_ALU2 = 2'b11
  } wb_sel_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with stall (hold) and flush (bubble) control.
// A held entry drops its valid bit so it retires only once.
module memwb_reg
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] alu_in,
  input  logic [DATA_WIDTH-1:0] mem_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [2:0]            w_reg_in,
  input  logic                  w_en_in,
  input  logic [1:0]            wb_sel_in,
  input  logic                  valid_in,
  input  logic                  halt_in,
  output logic [DATA_WIDTH-1:0] alu_q,
  output logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] pc_q,
  output logic [2:0]            w_reg_q,
  output logic                  w_en_q,
  output logic [1:0]            wb_sel_q,
  output logic                  valid_q,
  output logic                  halt_q
);

  logic [DATA_WIDTH-1:0] alu_d;
  logic [DATA_WIDTH-1:0] mem_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [2:0]            w_reg_d;
  logic                  w_en_d;
  logic [1:0]            wb_sel_d;
  logic                  valid_d;
  logic                  halt_d;

  always_comb begin
    alu_d    = alu_in;
    mem_d    = mem_in;
    pc_d     = pc_in;
    w_reg_d  = w_reg_in;
    w_en_d   = w_en_in;
    wb_sel_d = wb_sel_in;
    valid_d  = valid_in;
    halt_d   = halt_in;
    if (stall) begin
      // Hold everything, but the entry has already had its writeback cycle.
      alu_d    = alu_q;
      mem_d    = mem_q;
      pc_d     = pc_q;
      w_reg_d  = w_reg_q;
      w_en_d   = w_en_q;
      wb_sel_d = wb_sel_q;
      valid_d  = 1'b0;
      halt_d   = halt_q;
    end else if (flush) begin
      w_en_d  = 1'b0;
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q    <= '0;
      mem_q    <= '0;
      pc_q     <= '0;
      w_reg_q  <= '0;
      w_en_q   <= 1'b0;
      wb_sel_q <= '0;
      valid_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      pc_q     <= pc_d;
      w_reg_q  <= w_reg_d;
      w_en_q   <= w_en_d;
      wb_sel_q <= wb_sel_d;
      valid_q  <= valid_d;
      halt_q   <= halt_d;
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: result select, RUN/HALTED machine and retire counter.
// Optional read bypass compiled in with macro WB_BYPASS_EN.
module writeback
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] seq_PC,
  input  logic [2:0]            w_reg_pipe,
  input  logic                  reg_w_en_in,
  input  logic [1:0]            wb_sel,
  input  logic                  valid_in,
  input  logic                  halt_in,
  input  logic                  stall,
  input  logic                  flush,
`ifdef WB_BYPASS_EN
  input  logic [2:0]            rd1_sel,
  input  logic [2:0]            rd2_sel,
  input  logic [DATA_WIDTH-1:0] rd1_in,
  input  logic [DATA_WIDTH-1:0] rd2_in,
  output logic [DATA_WIDTH-1:0] rd1_out,
  output logic [DATA_WIDTH-1:0] rd2_out,
`endif
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [2:0]            w_reg_use,
  output logic                  reg_w_en,
  output logic                  wb_valid,
  output logic                  halted,
  output logic [15:0]           retire_cnt
);

  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [2:0]            w_reg_q;
  logic                  w_en_q;
  logic [1:0]            wb_sel_q;
  logic                  valid_q;
  logic                  halt_q;

  wb_state_e   state_q, state_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;

  memwb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_memwb_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .alu_in    (alu_out),
    .mem_in    (mem_data),
    .pc_in     (seq_PC),
    .w_reg_in  (w_reg_pipe),
    .w_en_in   (reg_w_en_in),
    .wb_sel_in (wb_sel),
    .valid_in  (valid_in),
    .halt_in   (halt_in),
    .alu_q     (alu_q),
    .mem_q     (mem_q),
    .pc_q      (pc_q),
    .w_reg_q   (w_reg_q),
    .w_en_q    (w_en_q),
    .wb_sel_q  (wb_sel_q),
    .valid_q   (valid_q),
    .halt_q    (halt_q)
  );

  always_comb begin
    case (wb_sel_e'(wb_sel_q))
      WB_SEL_MEM: w_data = mem_q;
      WB_SEL_PC:  w_data = pc_q;
      default:    w_data = alu_q;
    endcase
  end

  assign halted     = (state_q == ST_HALTED);
  assign wb_valid   = valid_q & ~halted;
  assign reg_w_en   = valid_q & w_en_q & ~halted;
  assign w_reg_use  = w_reg_q;
  assign retire_cnt = retire_cnt_q;

  // The HALT itself is counted in its own writeback cycle; nothing after it.
  always_comb begin
    state_d      = state_q;
    retire_cnt_d = retire_cnt_q;
    if (wb_valid) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
      if (halt_q) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign rd1_out = (reg_w_en && (rd1_sel == w_reg_use)) ? w_data : rd1_in;
  assign rd2_out = (reg_w_en && (rd2_sel == w_reg_use)) ? w_data : rd2_in;
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed vector table, hand-written
// halt/wrap/reset sequences and random traffic against a reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] alu_out, mem_data, seq_PC;
  logic [2:0]  w_reg_pipe;
  logic        reg_w_en_in, valid_in, halt_in, stall, flush;
  logic [1:0]  wb_sel;
  logic [15:0] w_data;
  logic [2:0]  w_reg_use;
  logic        reg_w_en, wb_valid, halted;
  logic [15:0] retire_cnt;
`ifdef WB_BYPASS_EN
  logic [2:0]  rd1_sel, rd2_sel;
  logic [15:0] rd1_in, rd2_in, rd1_out, rd2_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback #(.DATA_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_out     (alu_out),
    .mem_data    (mem_data),
    .seq_PC      (seq_PC),
    .w_reg_pipe  (w_reg_pipe),
    .reg_w_en_in (reg_w_en_in),
    .wb_sel      (wb_sel),
    .valid_in    (valid_in),
    .halt_in     (halt_in),
    .stall       (stall),
    .flush       (flush),
`ifdef WB_BYPASS_EN
    .rd1_sel     (rd1_sel),
    .rd2_sel     (rd2_sel),
    .rd1_in      (rd1_in),
    .rd2_in      (rd2_in),
    .rd1_out     (rd1_out),
    .rd2_out     (rd2_out),
`endif
    .w_data      (w_data),
    .w_reg_use   (w_reg_use),
    .reg_w_en    (reg_w_en),
    .wb_valid    (wb_valid),
    .halted      (halted),
    .retire_cnt  (retire_cnt)
  );

  // Reference model: the instruction currently sitting in writeback, whether
  // it still owes its single writeback cycle, and the architectural state.
  typedef struct {
    logic [15:0] alu, mem, pc;
    logic [2:0]  dst;
    logic        wen, halt;
    logic [1:0]  sel;
  } instr_t;

  instr_t      slot;
  bit          slotPending;
  bit          slotKnown;
  bit          mHalted;
  int unsigned mRetired;

  typedef struct {
    logic        stall, flush, valid, halt, wen;
    logic [1:0]  sel;
    logic [15:0] alu, mem, pc;
    logic [2:0]  dst;
    logic        chkData;
    logic [15:0] expData;
    logic [2:0]  expReg;
    logic        expWen, expValid, expHalted;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [15:0] resultOf(instr_t ins);
    if (ins.sel == 2'd1) return ins.mem;
    if (ins.sel == 2'd2) return ins.pc;
    return ins.alu;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    slot        = '{alu: 16'h0, mem: 16'h0, pc: 16'h0, dst: 3'd0, wen: 1'b0, halt: 1'b0, sel: 2'd0};
    slotPending = 0;
    slotKnown   = 1;
    mHalted     = 0;
    mRetired    = 0;
  endtask

  task automatic modelEdge();
    if (slotPending && !mHalted) begin
      mRetired = mRetired + 1;
      if (slot.halt) mHalted = 1;
    end
    if (stall) begin
      slotPending = 0;
    end else if (flush) begin
      slotPending = 0;
      slot.wen    = 1'b0;
      slot.halt   = 1'b0;
      slotKnown   = 0;
    end else begin
      slot = '{alu: alu_out, mem: mem_data, pc: seq_PC, dst: w_reg_pipe,
               wen: reg_w_en_in, halt: halt_in, sel: wb_sel};
      slotPending = valid_in;
      slotKnown   = 1;
    end
  endtask

  task automatic checkOutput();
    bit live;
    live = slotPending && !mHalted;
    if (slotKnown) begin
      cmp("w_data", w_data, resultOf(slot));
      cmp("w_reg_use", {13'd0, w_reg_use}, {13'd0, slot.dst});
    end
    cmp("wb_valid", {15'd0, wb_valid}, {15'd0, live});
    cmp("reg_w_en", {15'd0, reg_w_en}, {15'd0, live && slot.wen});
    cmp("halted", {15'd0, halted}, {15'd0, mHalted});
    cmp("retire_cnt", retire_cnt, mRetired[15:0]);
  endtask

  task automatic stepCycle(input bit doCheck);
    @(posedge clk);
    modelEdge();
    #1;
    if (doCheck) checkOutput();
  endtask

  task automatic applyStimulus(input vec_t v);
    stall       = v.stall;
    flush       = v.flush;
    valid_in    = v.valid;
    halt_in     = v.halt;
    reg_w_en_in = v.wen;
    wb_sel      = v.sel;
    alu_out     = v.alu;
    mem_data    = v.mem;
    seq_PC      = v.pc;
    w_reg_pipe  = v.dst;
  endtask

  task automatic randomInputs();
    alu_out     = 16'($urandom);
    mem_data    = 16'($urandom);
    seq_PC      = 16'($urandom);
    w_reg_pipe  = 3'($urandom);
    wb_sel      = 2'($urandom);
    reg_w_en_in = 1'($urandom);
    valid_in    = 1'($urandom);
    halt_in     = 1'($urandom);
    stall       = 1'($urandom);
    flush       = 1'($urandom);
  endtask

  task automatic idleInputs();
    applyStimulus('{default: '0});
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, "_w_data"}, w_data, 16'h0);
    cmp({tag, "_w_reg_use"}, {13'd0, w_reg_use}, 16'h0);
    cmp({tag, "_reg_w_en"}, {15'd0, reg_w_en}, 16'h0);
    cmp({tag, "_wb_valid"}, {15'd0, wb_valid}, 16'h0);
    cmp({tag, "_halted"}, {15'd0, halted}, 16'h0);
    cmp({tag, "_retire_cnt"}, retire_cnt, 16'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    randomInputs();
    modelReset();
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
  endtask

  initial begin
    //            stall flush valid halt wen sel   alu       mem       pc       dst  chk data      reg  wen val hlt cnt
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'h1234, 16'hABCD, 16'h0042, 3'd5, 1'b1, 16'h1234, 3'd5, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 16'h1234, 16'hABCD, 16'h0042, 3'd5, 1'b1, 16'hABCD, 3'd5, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 16'h1234, 16'hABCD, 16'h0042, 3'd5, 1'b1, 16'h0042, 3'd5, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 16'h1234, 16'hABCD, 16'h0042, 3'd5, 1'b1, 16'h1234, 3'd5, 1'b1, 1'b1, 1'b0, 16'd3};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h5555, 16'h6666, 16'h7777, 3'd2, 1'b1, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h5555, 16'h6666, 16'h7777, 3'd2, 1'b1, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h5555, 16'h6666, 16'h7777, 3'd2, 1'b1, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h5555, 16'h6666, 16'h7777, 3'd2, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd4};

    idleInputs();
`ifdef WB_BYPASS_EN
    rd1_sel = 3'd0; rd2_sel = 3'd0; rd1_in = 16'h0; rd2_in = 16'h0;
`endif
    modelReset();

    // Reset with random inputs, then idle cycles must stay quiet.
    doReset();
    repeat (3) stepCycle(1);
    checkAllZero("idle");

    // Directed select and stall/flush vectors.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      stepCycle(1);
      if (vecs[i].chkData) begin
        cmp($sformatf("vec%0d_w_data", i), w_data, vecs[i].expData);
        cmp($sformatf("vec%0d_w_reg_use", i), {13'd0, w_reg_use}, {13'd0, vecs[i].expReg});
      end
      cmp($sformatf("vec%0d_reg_w_en", i), {15'd0, reg_w_en}, {15'd0, vecs[i].expWen});
      cmp($sformatf("vec%0d_wb_valid", i), {15'd0, wb_valid}, {15'd0, vecs[i].expValid});
      cmp($sformatf("vec%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].expHalted});
      cmp($sformatf("vec%0d_retire_cnt", i), retire_cnt, vecs[i].expCnt);
    end

    // Randomized traffic without HALT, ending with an asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      halt_in = 1'b0;
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 5) == 0);
      stepCycle(1);
    end
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    checkAllZero("async");
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    stepCycle(1);

    // HALT followed by writes to r3.
    valid_in = 1'b1; halt_in = 1'b1; reg_w_en_in = 1'b0; w_reg_pipe = 3'd0;
    stepCycle(1);
    cmp("halt_in_wb_valid", {15'd0, wb_valid}, 16'h1);
    cmp("halt_in_wb_halted", {15'd0, halted}, 16'h0);
    halt_in = 1'b0; reg_w_en_in = 1'b1; w_reg_pipe = 3'd3; alu_out = 16'hBEEF;
    stepCycle(1);
    cmp("halt_cnt", retire_cnt, 16'd1);
    cmp("halt_halted", {15'd0, halted}, 16'h1);
    cmp("halt_reg_w_en", {15'd0, reg_w_en}, 16'h0);
    repeat (4) stepCycle(1);
    cmp("post_halt_reg_w_en", {15'd0, reg_w_en}, 16'h0);
    cmp("post_halt_cnt", retire_cnt, 16'd1);

    // Counter wrap: 65535 retirements, then one more.
    doReset();
    valid_in = 1'b1; reg_w_en_in = 1'b0;
    repeat (65536) stepCycle(0);
    checkOutput();
    cmp("wrap_ffff", retire_cnt, 16'hFFFF);
    stepCycle(1);
    cmp("wrap_zero", retire_cnt, 16'h0000);

`ifdef WB_BYPASS_EN
    doReset();
    valid_in = 1'b1; reg_w_en_in = 1'b1; w_reg_pipe = 3'd2; alu_out = 16'h00FF; wb_sel = 2'd0;
    stepCycle(1);
    rd1_sel = 3'd2; rd1_in = 16'h1111; rd2_sel = 3'd4; rd2_in = 16'($urandom);
    #1;
    cmp("bypass_rd1", rd1_out, 16'h00FF);
    cmp("bypass_rd2", rd2_out, rd2_in);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of every data path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 alu_out  input  DATA_WIDTH  execute result from MEM/WB boundary.
REQ-005 mem_data  input  DATA_WIDTH  data-memory read result.
REQ-006 seq_PC  input  DATA_WIDTH  PC+2 of the instruction (link value).
REQ-007 w_reg_pipe  input  3  destination register address piped from decode.
REQ-008 reg_w_en_in  input  1  instruction writes the register file.
REQ-009 wb_sel  input  2  result select: 00 alu_out, 01 mem_data, 10 seq_PC, 11 alu_out.
REQ-010 valid_in  input  1  MEM stage presents a real instruction.
REQ-011 halt_in  input  1  instruction is HALT.
REQ-012 stall  input  1  hold MEM/WB register contents.
REQ-013 flush  input  1  load a bubble instead of the MEM stage instruction.
REQ-014 w_data  output  DATA_WIDTH  register-file write data.
REQ-015 w_reg_use  output  3  register-file write address.
REQ-016 reg_w_en  output  1  register-file write strobe.
REQ-017 wb_valid  output  1  a valid instruction occupies writeback this cycle.
REQ-018 halted  output  1  sticky; HALT has retired.
REQ-019 retire_cnt  output  16  count of retired instructions.

Function
REQ-020 The MEM/WB register (data, address, w_en, wb_sel, valid, halt) SHALL load on each rising edge with stall=0; latency from input to output is exactly one cycle.
REQ-021 With stall=1 the register SHALL hold; stall takes priority over flush.
REQ-022 With flush=1 and stall=0 the register SHALL load valid=0, w_en=0, halt=0; the data fields are don't-care.
REQ-023 w_data SHALL be the registered value selected by registered wb_sel, combinationally from the register.
REQ-024 w_reg_use SHALL equal the registered w_reg_pipe.
REQ-025 reg_w_en SHALL be registered valid AND registered w_en AND NOT halted.
REQ-026 wb_valid SHALL be registered valid AND NOT halted.
REQ-027 State machine RUN/HALTED: RUN->HALTED on the rising edge after a cycle with wb_valid=1 and registered halt=1; HALTED is absorbing until reset; halted=1 in HALTED.
REQ-028 The HALT instruction itself SHALL retire (counted) but no instruction after it SHALL write or count.
REQ-029 retire_cnt SHALL increment by 1 on each rising edge following a cycle with wb_valid=1, wrapping 16'hFFFF->16'h0000.
REQ-030 A stalled instruction SHALL retire and count only once, in its first writeback cycle; during stall the held register presents valid=0 after that cycle.

Reset
REQ-031 While rst=0: MEM/WB register cleared to zero (bubble), state RUN, retire_cnt=0, hence w_data=0, w_reg_use=0, reg_w_en=0, wb_valid=0, halted=0.
REQ-032 Reset asserted mid-operation SHALL clear all state immediately, without waiting for clk; first load occurs on the first rising edge after rst returns to 1.

Configuration
REQ-033 Macro WB_BYPASS_EN SHALL compile in a read bypass: inputs rd1_sel/rd2_sel (3), rd1_in/rd2_in (DATA_WIDTH); outputs rd1_out/rd2_out equal w_data when reg_w_en=1 and sel==w_reg_use, else the corresponding _in value.
REQ-034 Without WB_BYPASS_EN those ports SHALL not exist and the block behaves otherwise identically.

Structure
REQ-035 A shared package SHALL hold the wb_sel encodings, the RUN/HALTED state encoding and DATA_WIDTH default.
REQ-036 The MEM/WB pipeline register SHALL be a sub-module named memwb_reg; select, halt FSM, counter and bypass live in writeback.

Verification
REQ-037 Reset: rst=0 with random inputs -> all outputs 0; release, apply nothing valid -> outputs stay 0.
REQ-038 Select: alu_out=16'h1234, mem_data=16'hABCD, seq_PC=16'h0042, w_reg_pipe=5, reg_w_en_in=1, valid_in=1, wb_sel 00/01/10/11 on successive cycles -> next cycles w_data 1234/ABCD/0042/1234, w_reg_use=5, reg_w_en=1.
REQ-039 Stall/flush: stall=1 with flush=1 for 3 cycles -> register held, retire_cnt +1 only; then flush=1 stall=0 -> reg_w_en=0, wb_valid=0.
REQ-040 Halt: valid HALT followed by valid writes to r3 -> retire_cnt increments by 1 for HALT, halted=1 next cycle, reg_w_en stays 0 thereafter.
REQ-041 Wrap: preload via 65535 retirements -> retire_cnt=16'hFFFF, one more -> 16'h0000.
REQ-042 Bypass (WB_BYPASS_EN): write r2=16'h00FF, rd1_sel=2, rd1_in=16'h1111, rd2_sel=4 -> rd1_out=16'h00FF, rd2_out=rd2_in.
